// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared occupancy states, bubble default and per-boundary widths
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // The bubble must decode as "no register write, no memory write" downstream.
  localparam int PIPE_CTRL_BUBBLE = 0;

  localparam int PIPE_CNT_W = 16;

  localparam int EXMEM_DATA_W     = 101;
  localparam int EXMEM_CTRL_IN_W  = 10;
  localparam int EXMEM_CTRL_LSB   = 6;
  localparam int EXMEM_CTRL_OUT_W = 4;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - occupancy state machine and second-entry register for the skid build
// Only instantiated when PIPE_SKID_EN is defined; in_ready comes from a flop.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = EXMEM_DATA_W + EXMEM_CTRL_OUT_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_word,
  input  logic         out_ready,
  output logic         in_ready,
  output logic         take_in,
  output logic         take_skid,
  output logic         drain,
  output logic [W-1:0] skid_word
);

  pipe_state_e  state;
  logic         rdy_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         consume;

  assign in_ready  = rdy_q && !flush;
  assign accept    = in_valid && in_ready;
  assign consume   = (state != EMPTY) && out_ready;
  assign skid_word = skid_q;

  // Tells the top-level main register what to load this cycle.
  always_comb begin
    take_in   = 1'b0;
    take_skid = 1'b0;
    drain     = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: take_in = accept;
        ONE: begin
          take_in = accept && consume;
          drain   = consume && !accept;
        end
        TWO:     take_skid = consume;
        default: take_in   = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= ONE;
        end
        ONE: begin
          if (accept && !consume) begin
            state  <= TWO;
            skid_q <= in_word;
            rdy_q  <= 1'b0;
          end else if (consume && !accept) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state <= ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush, control slicing, stall counter
// Define PIPE_SKID_EN for the two-entry skid buffer; otherwise a single register stage.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = EXMEM_DATA_W,
  parameter int CTRL_IN_W  = EXMEM_CTRL_IN_W,
  parameter int CTRL_LSB   = EXMEM_CTRL_LSB,
  parameter int CTRL_OUT_W = EXMEM_CTRL_OUT_W,
  parameter logic [CTRL_OUT_W-1:0] CTRL_BUBBLE = CTRL_OUT_W'(PIPE_CTRL_BUBBLE),
  parameter int CNT_W      = PIPE_CNT_W
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_IN_W-1:0]  in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_OUT_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int WORD_W = DATA_W + CTRL_OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CTRL_OUT_W-1:0] ctrl_slice;
  logic [WORD_W-1:0]     in_word;
  logic [WORD_W-1:0]     skid_word;
  logic                  take_in;
  logic                  take_skid;
  logic                  drain;
  logic                  valid_q;
  logic [DATA_W-1:0]     data_q;
  logic [CTRL_OUT_W-1:0] ctrl_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  unused_ctrl;

  // Only the downstream stage's slice of the control bundle is ever stored.
  assign ctrl_slice  = in_ctrl[CTRL_LSB +: CTRL_OUT_W];
  assign unused_ctrl = ^in_ctrl;
  assign in_word     = {ctrl_slice, in_data};

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .W (WORD_W)
  ) u_skid (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .take_in   (take_in),
    .take_skid (take_skid),
    .drain     (drain),
    .skid_word (skid_word)
  );
`else
  // Accept into an empty stage or into one being emptied this cycle.
  assign in_ready  = (!valid_q || out_ready) && !flush;
  assign take_in   = in_valid && in_ready;
  assign take_skid = 1'b0;
  assign drain     = valid_q && out_ready && !take_in;
  assign skid_word = '0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (take_in) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      ctrl_q  <= ctrl_slice;
    end else if (take_skid) begin
      valid_q          <= 1'b1;
      {ctrl_q, data_q} <= skid_word;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  // Counts back-pressure cycles only; a flush must not hide earlier stalls.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = valid_q ? ctrl_q : CTRL_BUBBLE;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - queue-model and directed-vector bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DW  = 101;
  localparam int CIW = 10;
  localparam int COW = 4;
  localparam int CW  = 4;
  localparam int CNT_SAT = (1 << CW) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic           clk;
  logic           nrst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [CIW-1:0] in_ctrl;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [COW-1:0] out_ctrl;
  logic [CW-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(
    .DATA_W      (DW),
    .CTRL_IN_W   (CIW),
    .CTRL_LSB    (6),
    .CTRL_OUT_W  (COW),
    .CTRL_BUBBLE (4'h0),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of held words, capacity 1 (pass-through ready) or 2 (registered ready).
  logic [DW-1:0]  qd[$];
  logic [COW-1:0] qc[$];
  int             mcnt  = 0;
  bit             zflag = 1'b1;
  bit             m_acc;
  bit             m_cons;
  bit             m_v;

  function automatic bit model_ready();
    if (flush) return 1'b0;
    if (SKID) return qd.size() < 2;
    return (qd.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      qd.delete();
      qc.delete();
      mcnt  = 0;
      zflag = 1'b1;
    end else begin
      m_acc  = in_valid && model_ready();
      m_cons = (qd.size() > 0) && out_ready;
      if ((qd.size() > 0) && !out_ready && (mcnt < CNT_SAT)) mcnt++;
      if (m_cons) begin
        void'(qd.pop_front());
        void'(qc.pop_front());
      end
      if (flush) begin
        qd.delete();
        qc.delete();
        zflag = 1'b1;
      end else if (m_acc) begin
        qd.push_back(in_data);
        qc.push_back(COW'((in_ctrl >> 6) & 10'hF));
        zflag = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    m_v = qd.size() > 0;
    check("out_valid", 128'(out_valid), 128'(m_v));
    check("out_ctrl", 128'(out_ctrl), m_v ? 128'(qc[0]) : 128'(0));
    if (m_v) check("out_data", 128'(out_data), 128'(qd[0]));
    else if (zflag) check("out_data_zero", 128'(out_data), 128'(0));
    check("in_ready", 128'(in_ready), 128'(model_ready()));
    check("stall_cnt", 128'(stall_cnt), 128'(mcnt));
  end

  function automatic logic [DW-1:0] mk(input int n);
    return {5'(n), 32'(n * 7 + 3), 32'hC0DE_0000 | 32'(n), 32'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nrst      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(16'h1234);
    in_ctrl   = 10'h3C0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    nrst     = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    out_ready = 1'b1;
    in_ctrl   = 10'h3C0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = mk(i);
      tick();
      check("stream_valid", 128'(out_valid), 128'(1));
      check("stream_data", 128'(out_data), 128'(mk(i)));
      check("stream_ctrl", 128'(out_ctrl), 128'(4'hF));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 128'(out_valid), 128'(0));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(10);
    in_ctrl   = 10'h0C0;
    tick();
    in_data = mk(11);
    in_ctrl = 10'h2C0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("stall_hold_data", 128'(out_data), 128'(mk(10)));
    check("stall_hold_ctrl", 128'(out_ctrl), 128'(4'h3));
    check("stall_cnt_5", 128'(stall_cnt), 128'(5));
    check("stall_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    tick();
    check("release_valid", 128'(out_valid), 128'(SKID ? 1 : 0));
    check("release_ctrl", 128'(out_ctrl), SKID ? 128'(4'hB) : 128'(0));
    tick();
    check("release_empty", 128'(out_valid), 128'(0));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(20);
    in_ctrl   = 10'h3C0;
    tick();
    in_data = mk(21);
    tick();
    flush   = 1'b1;
    in_data = mk(22);
    #1;
    check("flush_in_ready", 128'(in_ready), 128'(0));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_ctrl", 128'(out_ctrl), 128'(0));
    check("flush_data", 128'(out_data), 128'(0));
    check("flush_stall_cnt", 128'(stall_cnt), 128'(7));
    tick();
    check("flush_no_accept", 128'(out_valid), 128'(0));

    in_valid = 1'b1;
    in_data  = mk(30);
    tick();
    in_data = mk(31);
    tick();
    in_valid = 1'b0;
    #1;
    nrst = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_data", 128'(out_data), 128'(0));
    check("midrst_ctrl", 128'(out_ctrl), 128'(0));
    check("midrst_stall", 128'(stall_cnt), 128'(0));
    nrst      = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk(40);
    in_ctrl   = 10'h3C0;
    out_ready = 1'b1;
    tick();
    check("midrst_first_valid", 128'(out_valid), 128'(1));
    check("midrst_first_data", 128'(out_data), 128'(mk(40)));

    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (20) tick();
    check("sat_15", 128'(stall_cnt), 128'(15));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_after_flush", 128'(stall_cnt), 128'(15));
    check("sat_flush_valid", 128'(out_valid), 128'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
